pulse_extender_ctrl: RTL



---
 rtl/pulse_ext_pkg.sv | 14 +
 rtl/pulse_sync_edge.sv | 49 ++++
 rtl/pulse_extender_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pulse_ext_pkg.sv
// rtl/pulse_ext_pkg.sv - shared state encoding and default parameters for the pulse extender
package pulse_ext_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        EXTEND  = 2'd2
    } state_t;

    localparam int CNT_W_DEF       = 8;
    localparam int RATIO_W_DEF     = 4;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - multi-flop synchroniser with registered rise/fall detection
module pulse_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_prev;
    logic                   r_armed;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Rising edges are only reported once a genuine low has been sampled, so an
    // input that is already high when reset is released is never mistaken for a new pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_prev <= w_sync_out;
            r_rise <= w_sync_out & ~r_prev & r_armed;
            r_fall <= ~w_sync_out & r_prev;
            if (r_vld[SYNC_STAGES-1] && !w_sync_out) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/pulse_extender_ctrl.sv
// rtl/pulse_extender_ctrl.sv - measures an input pulse and emits it stretched by a ratio; PULSE_EXT_RETRIG_EN enables retrigger
module pulse_extender_ctrl
    import pulse_ext_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int RATIO_W     = RATIO_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               pulse_in,
    output logic               pulse_out,
    output logic               busy,
    output logic [CNT_W-1:0]   meas_len,
    output logic               ovf,
    output logic               done
);

`ifdef PULSE_EXT_RETRIG_EN
    localparam bit RETRIG_EN = 1'b1;
`else
    localparam bit RETRIG_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0]   LEN_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RATIO_W-1:0] RAT_ONE = {{(RATIO_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_len,      w_len_nxt;
    logic [CNT_W-1:0]     r_down,     w_down_nxt;
    logic [RATIO_W-1:0]   r_pre,      w_pre_nxt;
    logic [RATIO_W-1:0]   r_rat,      w_rat_nxt;
    logic [CNT_W-1:0]     r_meas_len, w_meas_nxt;
    logic                 r_ovf,      w_ovf_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_pulse,    w_pulse_nxt;
    logic                 r_retrig,   w_retrig_nxt;
    logic [RATIO_W-1:0]   w_rat_in;
    logic                 w_level;
    logic                 w_rise;
    logic                 w_fall;

    pulse_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (pulse_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_rat_in = (ratio == '0) ? RAT_ONE : ratio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_down     <= '0;
            r_pre      <= '0;
            r_rat      <= '0;
            r_meas_len <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_pulse    <= 1'b0;
            r_retrig   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_down     <= w_down_nxt;
            r_pre      <= w_pre_nxt;
            r_rat      <= w_rat_nxt;
            r_meas_len <= w_meas_nxt;
            r_ovf      <= w_ovf_nxt;
            r_done     <= w_done_nxt;
            r_pulse    <= w_pulse_nxt;
            r_retrig   <= w_retrig_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_down_nxt   = r_down;
        w_pre_nxt    = r_pre;
        w_rat_nxt    = r_rat;
        w_meas_nxt   = r_meas_len;
        w_ovf_nxt    = r_ovf;
        w_done_nxt   = 1'b0;
        w_retrig_nxt = r_retrig;

        if (!en) begin
            w_state_nxt  = IDLE;
            w_retrig_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = MEASURE;
                        w_len_nxt   = CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (w_fall) begin
                        w_state_nxt  = EXTEND;
                        w_meas_nxt   = r_len;
                        w_rat_nxt    = w_rat_in;
                        w_down_nxt   = r_len;
                        w_pre_nxt    = w_rat_in - RAT_ONE;
                        w_retrig_nxt = 1'b0;
                    end else if (w_level) begin
                        if (r_len == LEN_MAX) begin
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_len_nxt = r_len + CNT_ONE;
                        end
                    end
                end
                EXTEND: begin
                    if (RETRIG_EN && w_rise) begin
                        w_state_nxt  = MEASURE;
                        w_len_nxt    = CNT_ONE;
                        w_retrig_nxt = 1'b1;
                    end else if (r_pre != '0) begin
                        w_pre_nxt = r_pre - RAT_ONE;
                    end else begin
                        // Each unit of down lasts rat cycles; the last unit ends the extension.
                        w_pre_nxt = r_rat - RAT_ONE;
                        if (r_down <= CNT_ONE) begin
                            w_down_nxt  = '0;
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_down_nxt = r_down - CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        // A retriggered measurement keeps the output high after a single-cycle gap.
        w_pulse_nxt = (w_state_nxt == EXTEND) ||
                      ((w_state_nxt == MEASURE) && (r_state == MEASURE) && r_retrig);
    end

    assign pulse_out = r_pulse;
    assign busy      = (r_state != IDLE);
    assign meas_len  = r_meas_len;
    assign ovf       = r_ovf;
    assign done      = r_done;

endmodule
